// File: rtl/scan_double_pkg.sv
// Shared definitions for the scan doubler sequencer.
// Holds the sequencer state type, the default source and output timing constants,
// the source line width, and small line-count helpers used by the sequencer.
package scan_double_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSeek   = 2'd1,
        StLocked = 2'd2
    } seq_state_e;

    localparam int unsigned SRC_LINE_CLKS   = 1364;  // clocks per source line
    localparam int unsigned OUT_LINE_CLKS   = 682;   // clocks per output line
    localparam int unsigned OUT_FRAME_LINES = 524;   // output lines per frame
    localparam int unsigned SRC_WIDTH       = 256;   // source pixels per line
    localparam int unsigned CNT_W           = 10;    // hcount/vcount/read_x width

    // Line count after v, wrapping at v_last.
    function automatic logic [CNT_W-1:0] next_line(input logic [CNT_W-1:0] v,
                                                   input logic [CNT_W-1:0] v_last);
        return (v == v_last) ? '0 : v + CNT_W'(1);
    endfunction

    // Smallest even line count >= v, wrapping at the end of the frame.
    function automatic logic [CNT_W-1:0] round_up_even(input logic [CNT_W-1:0] v,
                                                       input logic [CNT_W-1:0] v_last);
        return v[0] ? next_line(v, v_last) : v;
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Output raster counter with synchronous load and sync/active decode.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   run_i               advance hcount/vcount by one clock
//   load_i, load_v_i    force hcount=0 and vcount=load_v_i (wins over run_i)
//   hcount_o, vcount_o  current position
//   h_active_o, v_active_o, hsync_o, vsync_o  combinational decode of the position
module video_timing_counter
    import scan_double_pkg::*;
#(
    parameter int unsigned H_TOTAL      = OUT_LINE_CLKS,
    parameter int unsigned H_ACTIVE     = 512,
    parameter int unsigned H_SYNC_START = 528,
    parameter int unsigned H_SYNC_LEN   = 64,
    parameter int unsigned V_TOTAL      = OUT_FRAME_LINES,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_SYNC_START = 490,
    parameter int unsigned V_SYNC_LEN   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_v_i,
    output logic [CNT_W-1:0] hcount_o,
    output logic [CNT_W-1:0] vcount_o,
    output logic             h_active_o,
    output logic             v_active_o,
    output logic             hsync_o,
    output logic             vsync_o
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_SYNC_START);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_SYNC_START);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_SYNC_START + V_SYNC_LEN);

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (load_i) begin
            hcount_d = '0;
            vcount_d = load_v_i;
        end else if (run_i) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = next_line(vcount_q, V_LAST);
            end else begin
                hcount_d = hcount_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign hcount_o   = hcount_q;
    assign vcount_o   = vcount_q;
    assign h_active_o = hcount_q < H_ACT;
    assign v_active_o = vcount_q < V_ACT;
    assign hsync_o    = (hcount_q >= HS_BEG) && (hcount_q < HS_END);
    assign vsync_o    = (vcount_q >= VS_BEG) && (vcount_q < VS_END);

endmodule

// File: rtl/scan_double_seq.sv
// Scan doubler sequencer: locks an output raster running at twice the source line
// rate to the source line/frame pulses and drives line-buffer bank control.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   enable                         run/stop; low forces IDLE on the next clock
//   in_frame_start, in_line_start  one-clock source timing pulses
//   reset_line, reset_frame        registered copies of the source pulses
//   wr_bank, rd_bank               line-buffer halves being written / read
//   read_x                         output pixel column (0 outside the active region)
//   hsync, vsync, de               active-high video timing, aligned to buffer read data
//   locked, slip_cnt               lock status and saturating resync count
module scan_double_seq
    import scan_double_pkg::*;
#(
    parameter int unsigned H_TOTAL      = OUT_LINE_CLKS,
    parameter int unsigned H_ACTIVE     = 512,
    parameter int unsigned H_SYNC_START = 528,
    parameter int unsigned H_SYNC_LEN   = 64,
    parameter int unsigned V_TOTAL      = OUT_FRAME_LINES,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_SYNC_START = 490,
    parameter int unsigned V_SYNC_LEN   = 2,
    parameter int unsigned PHASE_TOL    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_frame_start,
    input  logic             in_line_start,
    output logic             reset_line,
    output logic             reset_frame,
    output logic             wr_bank,
    output logic             rd_bank,
    output logic [CNT_W-1:0] read_x,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             locked,
    output logic [7:0]       slip_cnt
);

    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] TOL     = CNT_W'(PHASE_TOL);
    localparam logic [CNT_W-1:0] H_EARLY = CNT_W'(H_TOTAL - PHASE_TOL);

    seq_state_e       state_q, state_d;
    logic             line_q, frame_q;
    logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [1:0]       miss_q, miss_d;
    logic [7:0]       slip_q, slip_d;
    logic [CNT_W-1:0] read_x_q, read_x_d;
    logic             act_q, act_d, hs_q, hs_d, vs_q, vs_d;
    logic             de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;

    logic             cnt_load;
    logic [CNT_W-1:0] load_v;
    logic [CNT_W-1:0] hcount, vcount;
    logic             h_active, v_active, hsync_raw, vsync_raw;
    logic             is_locked, check, phase_ok, miss, frame_fix, out_en;
    logic [CNT_W-1:0] boundary_v;

    video_timing_counter #(
        .H_TOTAL      (H_TOTAL),
        .H_ACTIVE     (H_ACTIVE),
        .H_SYNC_START (H_SYNC_START),
        .H_SYNC_LEN   (H_SYNC_LEN),
        .V_TOTAL      (V_TOTAL),
        .V_ACTIVE     (V_ACTIVE),
        .V_SYNC_START (V_SYNC_START),
        .V_SYNC_LEN   (V_SYNC_LEN)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (is_locked),
        .load_i     (cnt_load),
        .load_v_i   (load_v),
        .hcount_o   (hcount),
        .vcount_o   (vcount),
        .h_active_o (h_active),
        .v_active_o (v_active),
        .hsync_o    (hsync_raw),
        .vsync_o    (vsync_raw)
    );

    assign is_locked = (state_q == StLocked);
    assign check     = is_locked && (line_q || frame_q);
    // A source line start belongs at hcount=0 of an even output line; a pulse just
    // before the wrap of an odd line is equally close to that boundary.
    assign phase_ok  = (!vcount[0] && (hcount <= TOL)) || (vcount[0] && (hcount >= H_EARLY));
    assign miss      = check && !phase_ok;
    // Output line whose start the pulse is nearest to; a frame pulse must land on line 0.
    assign boundary_v = (hcount >= H_EARLY) ? next_line(vcount, V_LAST) : vcount;
    assign frame_fix  = is_locked && frame_q && (boundary_v != '0);

    always_comb begin
        state_d   = state_q;
        miss_d    = miss_q;
        slip_d    = slip_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        cnt_load  = 1'b0;
        load_v    = '0;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StSeek;
            end
            StSeek: begin
                if (enable && in_frame_start) begin
                    state_d   = StLocked;
                    cnt_load  = 1'b1;
                    wr_bank_d = 1'b0;
                    miss_d    = '0;
                end
            end
            StLocked: begin
                // Both bank updates use the pre-toggle wr_bank when they coincide.
                if ((hcount == '0) && !vcount[0]) rd_bank_d = ~wr_bank_q;
                if (line_q) wr_bank_d = ~wr_bank_q;
                if (check) miss_d = phase_ok ? 2'd0 : miss_q + 2'd1;
                if (miss || frame_fix) begin
                    cnt_load = 1'b1;
                    load_v   = frame_q ? '0 : round_up_even(vcount, V_LAST);
                    if (slip_q != 8'hff) slip_d = slip_q + 8'd1;
                end
                if (miss && (miss_q == 2'd2)) begin
                    state_d = StSeek;
                    miss_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!enable) state_d = StIdle;
    end

    // Outputs are gated by the next state so they drop on the same edge that leaves LOCKED.
    always_comb begin
        out_en   = is_locked && (state_d == StLocked);
        read_x_d = (out_en && h_active) ? hcount : '0;
        act_d    = out_en && h_active && v_active;
        hs_d     = out_en && hsync_raw;
        vs_d     = out_en && vsync_raw;
        // Extra stage covers the line buffer's one-cycle read latency.
        de_d     = (state_d == StLocked) && act_q;
        hsync_d  = (state_d == StLocked) && hs_q;
        vsync_d  = (state_d == StLocked) && vs_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            miss_q    <= '0;
            slip_q    <= '0;
            read_x_q  <= '0;
            act_q     <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= in_line_start;
            frame_q   <= in_frame_start;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            miss_q    <= miss_d;
            slip_q    <= slip_d;
            read_x_q  <= read_x_d;
            act_q     <= act_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
        end
    end

    assign reset_line  = line_q;
    assign reset_frame = frame_q;
    assign wr_bank     = wr_bank_q;
    assign rd_bank     = rd_bank_q;
    assign read_x      = read_x_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign locked      = is_locked;
    assign slip_cnt    = slip_q;

endmodule

// File: tb/tb_scan_double_seq.sv
// Directed bench for scan_double_seq on a reduced raster: 40 clocks per output line
// (80-clock source line), 24 active pixels, hsync 28..33, 12 lines, 8 active, vsync 9..10.
// Step n is the clock edge counted from the locking frame pulse (n=0).
module tb_scan_double_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       in_frame_start = 1'b0;
    logic       in_line_start = 1'b0;
    logic       reset_line, reset_frame, wr_bank, rd_bank, hsync, vsync, de, locked;
    logic [9:0] read_x;
    logic [7:0] slip_cnt;

    int checks = 0;
    int failures = 0;
    int n = 0;
    int de_cnt = 0;
    int lk_cnt = 0;

    always #5 clk = ~clk;

    scan_double_seq #(
        .H_TOTAL      (40),
        .H_ACTIVE     (24),
        .H_SYNC_START (28),
        .H_SYNC_LEN   (6),
        .V_TOTAL      (12),
        .V_ACTIVE     (8),
        .V_SYNC_START (9),
        .V_SYNC_LEN   (2),
        .PHASE_TOL    (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .in_frame_start (in_frame_start),
        .in_line_start  (in_line_start),
        .reset_line     (reset_line),
        .reset_frame    (reset_frame),
        .wr_bank        (wr_bank),
        .rd_bank        (rd_bank),
        .read_x         (read_x),
        .hsync          (hsync),
        .vsync          (vsync),
        .de             (de),
        .locked         (locked),
        .slip_cnt       (slip_cnt)
    );

    typedef struct {
        int         n;
        logic       lk, de, hs, vs, wr, rd;
        logic [9:0] x;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0d want=%0d", name, n, act, exp);
        end
    endtask

    // Drive one clock of source pulses, then sample just after the edge.
    task automatic step(input logic fs, input logic ls);
        in_frame_start = fs;
        in_line_start  = ls;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input vec_t v);
        chk("locked", {31'd0, locked}, {31'd0, v.lk});
        chk("de", {31'd0, de}, {31'd0, v.de});
        chk("hsync", {31'd0, hsync}, {31'd0, v.hs});
        chk("vsync", {31'd0, vsync}, {31'd0, v.vs});
        chk("wr_bank", {31'd0, wr_bank}, {31'd0, v.wr});
        chk("rd_bank", {31'd0, rd_bank}, {31'd0, v.rd});
        chk("read_x", {22'd0, read_x}, {22'd0, v.x});
    endtask

    initial begin
        //                n    lk    de    hs    vs    wr    rd    x
        tbl.push_back('{0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0});
        tbl.push_back('{1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0});
        tbl.push_back('{2,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'd1});
        tbl.push_back('{5,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'd4});
        tbl.push_back('{25,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0});
        tbl.push_back('{26,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0});
        tbl.push_back('{30,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'd0});
        tbl.push_back('{35,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'd0});
        tbl.push_back('{36,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0});
        tbl.push_back('{42,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'd1});
        tbl.push_back('{81,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0});
        tbl.push_back('{83,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd2});
        tbl.push_back('{161, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0});
        tbl.push_back('{305, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0});
        tbl.push_back('{322, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd1});
        tbl.push_back('{361, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0});
        tbl.push_back('{362, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd1});
        tbl.push_back('{441, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0});
        tbl.push_back('{442, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd1});
        tbl.push_back('{482, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'd1});
        tbl.push_back('{512, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10'd0});

        // Asynchronous reset state.
        #2 rst_n = 1'b0;
        #2;
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_de", {31'd0, de}, 32'd0);
        chk("rst_slip", {24'd0, slip_cnt}, 32'd0);
        chk("rst_read_x", {22'd0, read_x}, 32'd0);
        chk("rst_banks", {30'd0, wr_bank, rd_bank}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores frame pulses but still mirrors them.
        step(1'b1, 1'b0);
        chk("idle_locked", {31'd0, locked}, 32'd0);
        chk("idle_reset_frame", {31'd0, reset_frame}, 32'd1);
        step(1'b0, 1'b0);
        chk("idle_reset_frame_clr", {31'd0, reset_frame}, 32'd0);
        enable = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("seek_line_only", {31'd0, locked}, 32'd0);

        // Nominal timing, frame pulse at n=0.
        for (n = 0; n < 640; n++) begin
            step(n % 480 == 0, n % 80 == 0);
            if (n >= 2 && n <= 481 && de) de_cnt++;
            foreach (tbl[i]) if (tbl[i].n == n) check_vec(tbl[i]);
        end
        chk("de_clocks_per_frame", de_cnt, 32'd192);
        chk("nominal_slip", {24'd0, slip_cnt}, 32'd0);

        // One line pulse 10 clocks late; the source stays on the new phase.
        for (n = 640; n < 820; n++) begin
            step(1'b0, n >= 650 && (n - 650) % 80 == 0);
            if (n == 651) begin
                chk("late_slip", {24'd0, slip_cnt}, 32'd1);
                chk("late_locked", {31'd0, locked}, 32'd1);
            end
            if (n == 652) chk("late_hcount0", {22'd0, read_x}, 32'd0);
            if (n == 653) chk("late_hcount1", {22'd0, read_x}, 32'd1);
        end
        chk("late_slip_stable", {24'd0, slip_cnt}, 32'd1);

        // Three consecutive pulses 20 clocks early.
        for (n = 820; n < 1000; n++) begin
            step(1'b0, n == 870 || n == 930 || n == 990);
            if (n == 871) begin
                chk("early1_locked", {31'd0, locked}, 32'd1);
                chk("early1_slip", {24'd0, slip_cnt}, 32'd2);
            end
            if (n == 931) begin
                chk("early2_locked", {31'd0, locked}, 32'd1);
                chk("early2_slip", {24'd0, slip_cnt}, 32'd3);
            end
            if (n == 991) begin
                chk("early3_locked", {31'd0, locked}, 32'd0);
                chk("early3_slip", {24'd0, slip_cnt}, 32'd4);
            end
            if (n == 995) begin
                chk("seek_de", {31'd0, de}, 32'd0);
                chk("seek_read_x", {22'd0, read_x}, 32'd0);
            end
        end

        // Re-lock on a fresh frame pulse.
        for (n = 1000; n < 1010; n++) begin
            step(n == 1000, n == 1000);
            if (n == 1000) chk("relock", {31'd0, locked}, 32'd1);
            if (n == 1001) chk("relock_wr_bank", {31'd0, wr_bank}, 32'd1);
            if (n == 1002) begin
                chk("relock_de", {31'd0, de}, 32'd1);
                chk("relock_read_x", {22'd0, read_x}, 32'd1);
            end
            if (n == 1009) chk("pre_disable_de", {31'd0, de}, 32'd1);
        end

        // Drop enable while locked.
        enable = 1'b0;
        n = 1010;
        step(1'b0, 1'b1);
        chk("dis_locked", {31'd0, locked}, 32'd0);
        chk("dis_de", {31'd0, de}, 32'd0);
        chk("dis_syncs", {30'd0, hsync, vsync}, 32'd0);
        chk("dis_read_x", {22'd0, read_x}, 32'd0);
        chk("dis_reset_line", {31'd0, reset_line}, 32'd1);
        n = 1011;
        step(1'b0, 1'b0);
        chk("dis_reset_line_clr", {31'd0, reset_line}, 32'd0);
        n = 1012;
        step(1'b1, 1'b0);
        chk("dis_reset_frame", {31'd0, reset_frame}, 32'd1);
        for (n = 1013; n < 1020; n++) step(1'b0, 1'b0);
        chk("dis_stays_idle", {31'd0, locked}, 32'd0);

        // Lock again, then reset mid-line.
        enable = 1'b1;
        for (n = 1020; n < 1200; n++) begin
            step(n == 1030, n >= 1030 && (n - 1030) % 80 == 0);
            if (n == 1031) chk("e_locked", {31'd0, locked}, 32'd1);
        end
        chk("pre_rst_de", {31'd0, de}, 32'd1);
        chk("pre_rst_wr_bank", {31'd0, wr_bank}, 32'd1);
        chk("pre_rst_slip", {24'd0, slip_cnt}, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_locked", {31'd0, locked}, 32'd0);
        chk("mid_rst_de", {31'd0, de}, 32'd0);
        chk("mid_rst_slip", {24'd0, slip_cnt}, 32'd0);
        chk("mid_rst_wr_bank", {31'd0, wr_bank}, 32'd0);
        chk("mid_rst_read_x", {22'd0, read_x}, 32'd0);
        #2 rst_n = 1'b1;

        // Line pulses alone must not bring the raster back.
        de_cnt = 0;
        for (n = 1200; n < 1400; n++) begin
            step(1'b0, (n - 1030) % 80 == 0);
            if (de) de_cnt++;
            if (locked) lk_cnt++;
        end
        chk("post_rst_de_clocks", de_cnt, 32'd0);
        chk("post_rst_locked_clocks", lk_cnt, 32'd0);
        n = 1400;
        step(1'b1, 1'b1);
        chk("post_rst_relock", {31'd0, locked}, 32'd1);
        n = 1401;
        step(1'b0, 1'b0);
        n = 1402;
        step(1'b0, 1'b0);
        chk("post_rst_de", {31'd0, de}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_double_seq.md
SCAN_DOUBLE_SEQ -- requirements
Module: scan_double_seq

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: H_TOTAL, 682, output clocks per output line (half of the 1364-clock input line); H_ACTIVE, 512, active output pixels per line; H_SYNC_START, 528, first hsync clock; H_SYNC_LEN, 64, hsync width.
REQ-002 Further parameters SHALL be: V_TOTAL, 524, output lines per frame; V_ACTIVE, 480, active output lines; V_SYNC_START, 490, first vsync line; V_SYNC_LEN, 2, vsync width in lines; PHASE_TOL, 4, allowed line-phase error in clocks.
REQ-003 Ports (name, direction, width, meaning) SHALL be as listed in REQ-004 to REQ-007.
REQ-004 Clock and reset: clk, in, 1, sole clock; rst_n, in, 1, asynchronous active-low reset.
REQ-005 Inputs: enable, in, 1, run/stop; in_frame_start, in, 1, one-clock pulse at source line 0; in_line_start, in, 1, one-clock pulse at each source line start.
REQ-006 Doubler control outputs: reset_line, out, 1, registered copy of in_line_start; reset_frame, out, 1, registered copy of in_frame_start; wr_bank, out, 1, line-buffer half being written; rd_bank, out, 1, line-buffer half being read; read_x, out, 10, output pixel column.
REQ-007 Video outputs: hsync, out, 1; vsync, out, 1; de, out, 1, data enable; locked, out, 1; slip_cnt, out, 8, saturating resync counter.

Function
REQ-008 FSM states SHALL be IDLE, SEEK and LOCKED.
REQ-009 IDLE SHALL move to SEEK when enable=1; from any state, enable=0 SHALL return the FSM to IDLE on the next clock.
REQ-010 SEEK SHALL move to LOCKED on in_frame_start, loading hcount=0, vcount=0, and wr_bank=0 on that same edge.
REQ-011 In LOCKED, hcount SHALL run 0..H_TOTAL-1 and wrap to 0; vcount SHALL increment at each hcount wrap and wrap from V_TOTAL-1 to 0.
REQ-012 On in_line_start in LOCKED, the phase error SHALL be hcount compared with 0 on an even vcount, modulo H_TOTAL.
REQ-013 If |phase error| <= PHASE_TOL, counters SHALL be left unchanged and the miss counter SHALL be cleared.
REQ-014 Otherwise, hcount SHALL be forced to 0, vcount rounded up to the next even value, slip_cnt incremented (saturating at 255), and the miss counter incremented.
REQ-015 Three consecutive misses SHALL return the FSM to SEEK.
REQ-016 wr_bank SHALL toggle on every in_line_start while LOCKED; at hcount=0 of each even vcount, rd_bank SHALL load ~wr_bank.
REQ-017 If in_line_start and the even-line hcount=0 occur on the same clock, the pre-toggle wr_bank SHALL be used for both actions.
REQ-018 read_x SHALL equal hcount when hcount < H_ACTIVE, and SHALL be 0 otherwise (registered).
REQ-019 de SHALL assert one clock after read_x enters the active region, covering the doubler's 1-cycle read latency, and only while vcount < V_ACTIVE.
REQ-020 hsync and vsync SHALL be active-high, delayed by the same 1 clock as de.
REQ-021 locked SHALL be 1 only in LOCKED.
REQ-022 Outside LOCKED, hsync, vsync, de and read_x SHALL be 0, while reset_line and reset_frame SHALL keep passing through.
REQ-023 in_frame_start in LOCKED SHALL trigger the REQ-012 check and additionally SHALL force vcount=0 when vcount != 0, counting as a slip.

Reset
REQ-024 On rst_n=0, all outputs, counters, banks and the miss counter SHALL clear to 0, with FSM=IDLE, asynchronously.
REQ-025 Reset deassertion mid-frame SHALL require a fresh in_frame_start to reach LOCKED; no partial line SHALL be presented with de=1.

Structure
REQ-026 A shared package scan_double_pkg SHALL hold the FSM state enum, default timing constants (1364, 682, 524) and the 256-pixel source width.
REQ-027 A single sub-module, video_timing_counter (hcount/vcount with load and sync decode), is natural; everything else SHALL be inline.

Verification
REQ-028 enable=1, in_frame_start at t0, in_line_start every 1364 clocks -> locked=1 one clock after t0, slip_cnt stays 0, and de is high for 512 clocks on each of 480 lines per frame.
REQ-029 One line pulse arriving 10 clocks late -> slip_cnt=1, hcount reads 0 on the next clock, locked stays 1.
REQ-030 Three consecutive line pulses each 20 clocks early -> locked drops after the third pulse, then re-locks on the next in_frame_start.
REQ-031 Bank check: after the line-0 pulse wr_bank=1, and at output line 2 (hcount=0) rd_bank=0; buffer halves alternate every source line.
REQ-032 rst_n pulsed low mid-line 100 -> all outputs 0 immediately; after release, de stays 0 until in_frame_start.
REQ-033 enable dropped while LOCKED -> FSM=IDLE next clock, de/hsync/vsync=0, and reset_line still mirrors in_line_start.
